// File: rtl/booth_mul_seq_32.sv
// rtl/booth_mul_seq_32.sv - sequential signed multiplier, radix-4 Booth recoding
// Two multiplier bits are retired per RUN cycle; {HI,LO} packs like the divider's {rem,quot}.
module booth_mul_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_multiplicand,
  input  logic [WIDTH-1:0]     b_multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c_product
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH+1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH+1:0]     m_ext;
  logic [WIDTH+1:0]     pp;
  logic [WIDTH+1:0]     sum;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Two guard bits keep +/-2M exact even for M = -2^(WIDTH-1).
  always_comb begin
    m_ext = {{2{m_q[WIDTH-1]}}, m_q};
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum = acc_q + pp;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a_multiplicand;
          q_d     = b_multiplier;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        q_d   = {sum[1:0], q_q[WIDTH-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          prod_d  = {acc_d[WIDTH-1:0], q_d};
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign c_product = prod_q;

endmodule
